modn_down_counter: RTL and testbench

Synchronous modulo-N down counter. It is the counting-direction complement of the team's ripple mod-N up counters.
- Loads a start value, decrements on enable, wraps from 0 to MODULUS-1.
- Free-running or one-shot mode, selected at load.
- Borrow output cascades into higher-order counter stages; also serves as a programmable timeout/divider.

---
 rtl/modn_cnt_pkg.sv | 20 ++
 rtl/modn_dec_cell.sv | 41 ++++
 rtl/modn_down_counter.sv | 123 ++++++++++++
 tb/tb_modn_down_counter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/modn_cnt_pkg.sv
// Shared definitions for the modulo-N counter family.
//   cnt_state_e : controller states (IDLE, RUN, DONE)
//   WRAP_CNT_W  : width of the optional saturating wrap counter
//   clamp_load  : limits a requested start value to modulus-1
package modn_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } cnt_state_e;

  localparam int unsigned WRAP_CNT_W = 8;

  function automatic int unsigned clamp_load(input int unsigned val,
                                             input int unsigned modulus);
    return (val >= modulus) ? modulus - 1 : val;
  endfunction

endpackage

// File: rtl/modn_dec_cell.sv
// Combinational next-value logic for one modulo-N down-count step.
// Ports:
//   q        in  current count
//   en       in  step request
//   mode     in  1 = one-shot (stop at 0), 0 = free-run (wrap to MODULUS-1)
//   q_next   out value after this step (q when en=0)
//   wrap_hit out borrow event: 0->MODULUS-1 (free-run) or 1->0 (one-shot)
//   term_hit out one-shot step attempted while already at 0
module modn_dec_cell #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 3
) (
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] q_next,
  output logic             wrap_hit,
  output logic             term_hit
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  always_comb begin
    q_next   = q;
    wrap_hit = 1'b0;
    term_hit = 1'b0;
    if (en) begin
      if (q != '0) begin
        q_next   = q - WIDTH'(1);
        wrap_hit = mode && (q == WIDTH'(1));
      end else if (mode) begin
        term_hit = 1'b1;
      end else begin
        // explicit wrap to the top of the range, never to 2**WIDTH-1
        q_next   = TOP;
        wrap_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/modn_down_counter.sv
// Synchronous modulo-N down counter with load, one-shot/free-run mode,
// abort and a registered borrow pulse for cascading or timeout use.
// Optional feature macro: MODN_DOWN_WRAP_CNT_EN adds an 8-bit saturating
// count of borrow pulses (wrap_cnt), cleared by reset and accepted load.
// Ports:
//   clk      in  rising-edge clock
//   reset    in  asynchronous active-low reset
//   load     in  start request, accepted when load_rdy=1
//   load_val in  start value, clamped to MODULUS-1
//   oneshot  in  mode captured with an accepted load
//   en       in  count enable in RUN
//   abort    in  return to IDLE from RUN/DONE, count preserved
//   load_rdy out high in IDLE and DONE
//   q        out registered count
//   borrow   out one-cycle registered wrap/terminal pulse
//   busy     out high in RUN
//   done     out high in DONE
//   wrap_cnt out (optional) saturating borrow count
module modn_down_counter
  import modn_cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  oneshot,
  input  logic                  en,
  input  logic                  abort,
  output logic                  load_rdy,
  output logic [WIDTH-1:0]      q,
  output logic                  borrow,
  output logic                  busy,
  output logic                  done
`ifdef MODN_DOWN_WRAP_CNT_EN
  ,
  output logic [WRAP_CNT_W-1:0] wrap_cnt
`endif
);

  cnt_state_e       state, state_nxt;
  logic [WIDTH-1:0] q_nxt, cell_q;
  logic             mode, mode_nxt;
  logic             borrow_nxt;
  logic             wrap_hit, term_hit;

  modn_dec_cell #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_dec (
    .q       (q),
    .en      (en),
    .mode    (mode),
    .q_next  (cell_q),
    .wrap_hit(wrap_hit),
    .term_hit(term_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      q      <= '0;
      mode   <= 1'b0;
      borrow <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      mode   <= mode_nxt;
      borrow <= borrow_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    mode_nxt   = mode;
    borrow_nxt = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        // load outranks abort outside RUN
        if (load) begin
          q_nxt     = WIDTH'(clamp_load(32'(load_val), MODULUS));
          mode_nxt  = oneshot;
          state_nxt = ST_RUN;
        end else if (abort && (state == ST_DONE)) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (en) begin
          q_nxt      = cell_q;
          borrow_nxt = wrap_hit;
          if (term_hit) state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign load_rdy = (state == ST_IDLE) || (state == ST_DONE);
  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);

`ifdef MODN_DOWN_WRAP_CNT_EN
  logic load_acc;
  assign load_acc = load_rdy & load;

  // advances on the same edge that raises borrow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wrap_cnt <= '0;
    else if (load_acc)
      wrap_cnt <= '0;
    else if (borrow_nxt && (wrap_cnt != '1))
      wrap_cnt <= wrap_cnt + WRAP_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_modn_down_counter.sv
module tb_modn_down_counter;

  localparam int W   = 3;
  localparam int MOD = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         load, oneshot, en, abort;
  logic [W-1:0] load_val;
  logic         load_rdy, borrow, busy, done;
  logic [W-1:0] q;
`ifdef MODN_DOWN_WRAP_CNT_EN
  logic [7:0]   wrap_cnt;
`endif

  modn_down_counter #(
    .WIDTH  (W),
    .MODULUS(MOD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_val(load_val),
    .oneshot (oneshot),
    .en      (en),
    .abort   (abort),
    .load_rdy(load_rdy),
    .q       (q),
    .borrow  (borrow),
    .busy    (busy),
    .done    (done)
`ifdef MODN_DOWN_WRAP_CNT_EN
    ,
    .wrap_cnt(wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_RUN, M_DONE} mst_e;

  typedef struct packed {
    logic [W-1:0] q;
    logic         borrow;
    logic         busy;
    logic         done;
    logic         rdy;
    logic [7:0]   wc;
  } exp_t;

  exp_t         sb[$];
  int           n_chk  = 0;
  int           n_fail = 0;

  mst_e         m_st;
  logic [W-1:0] m_q;
  logic         m_mode;
  logic         m_b;
  logic [7:0]   m_wc;

  int fr_q[6]  = '{1, 0, 2, 1, 0, 2};
  int fr_b[6]  = '{0, 0, 1, 0, 0, 1};
  int tg_en[4] = '{1, 0, 0, 1};
  int tg_q[4]  = '{1, 1, 1, 0};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st   = M_IDLE;
    m_q    = '0;
    m_mode = 1'b0;
    m_b    = 1'b0;
    m_wc   = '0;
  endtask

  // drive one cycle of stimulus, predict the outcome, compare after the edge
  task automatic step(input logic l, input logic [W-1:0] lv, input logic os,
                      input logic e, input logic ab);
    exp_t x;
    load = l; load_val = lv; oneshot = os; en = e; abort = ab;
    m_b = 1'b0;
    if (m_st != M_RUN) begin
      if (l) begin
        m_q    = (int'(lv) >= MOD) ? W'(MOD - 1) : lv;
        m_mode = os;
        m_st   = M_RUN;
        m_wc   = '0;
      end else if (ab && m_st == M_DONE) begin
        m_st = M_IDLE;
      end
    end else if (ab) begin
      m_st = M_IDLE;
    end else if (e) begin
      if (m_q == 0) begin
        if (m_mode) m_st = M_DONE;
        else begin
          m_q = W'(MOD - 1);
          m_b = 1'b1;
        end
      end else begin
        m_q = m_q - 1'b1;
        m_b = m_mode && (m_q == 0);
      end
    end
    if (m_b && m_wc != 8'hFF) m_wc = m_wc + 8'd1;
    x.q      = m_q;
    x.borrow = m_b;
    x.busy   = (m_st == M_RUN);
    x.done   = (m_st == M_DONE);
    x.rdy    = (m_st != M_RUN);
    x.wc     = m_wc;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("q", 32'(q), 32'(x.q));
    check("borrow", 32'(borrow), 32'(x.borrow));
    check("busy", 32'(busy), 32'(x.busy));
    check("done", 32'(done), 32'(x.done));
    check("load_rdy", 32'(load_rdy), 32'(x.rdy));
`ifdef MODN_DOWN_WRAP_CNT_EN
    check("wrap_cnt", 32'(wrap_cnt), 32'(x.wc));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    load = 0; load_val = '0; oneshot = 0; en = 0; abort = 0;
    reset = 1'b1;
    model_reset();
    #1 reset = 1'b0;
    #2;
    check("rst_q", 32'(q), 0);
    check("rst_borrow", 32'(borrow), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rdy", 32'(load_rdy), 1);
    @(posedge clk);
    #2 reset = 1'b1;

    // free-run from 2 with continuous enable
    step(1, 3'd2, 0, 1, 0);
    check("fr_load_q", 32'(q), 2);
    for (int i = 0; i < 6; i++) begin
      step(0, 3'd0, 0, 1, 0);
      check("fr_seq_q", 32'(q), 32'(fr_q[i]));
      check("fr_seq_b", 32'(borrow), 32'(fr_b[i]));
    end
    step(0, 3'd0, 0, 1, 1);
    check("abort_hold_q", 32'(q), 2);

    // one-shot from 2
    step(1, 3'd2, 1, 0, 0);
    step(0, 3'd0, 0, 1, 0);
    check("os_q1", 32'(q), 1);
    step(0, 3'd0, 0, 1, 0);
    check("os_q0", 32'(q), 0);
    check("os_borrow", 32'(borrow), 1);
    step(0, 3'd0, 0, 1, 0);
    check("os_done", 32'(done), 1);
    check("os_busy", 32'(busy), 0);
    check("os_noborrow", 32'(borrow), 0);
    step(0, 3'd0, 0, 1, 0);
    check("os_hold_q", 32'(q), 0);

    // clamped load from DONE
    step(1, 3'd7, 0, 0, 0);
    check("clamp_q", 32'(q), 2);
    check("clamp_done", 32'(done), 0);

    // enable toggling
    for (int i = 0; i < 4; i++) begin
      step(0, 3'd0, 0, tg_en[i] != 0, 0);
      check("tog_q", 32'(q), 32'(tg_q[i]));
      check("tog_b", 32'(borrow), 0);
    end
    step(0, 3'd0, 0, 1, 0);
    check("tog_wrap_q", 32'(q), 2);

    // asynchronous reset in the middle of a cycle while running at q=2
    #3 reset = 1'b0;
    model_reset();
    #1;
    check("arst_q", 32'(q), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_rdy", 32'(load_rdy), 1);
    check("arst_borrow", 32'(borrow), 0);
    #1 reset = 1'b1;

    // abort at q=1 with a simultaneous load that must be ignored
    step(1, 3'd2, 0, 0, 0);
    step(0, 3'd0, 0, 1, 0);
    step(1, 3'd0, 1, 1, 1);
    check("ab_q", 32'(q), 1);
    check("ab_rdy", 32'(load_rdy), 1);
    check("ab_busy", 32'(busy), 0);
    step(1, 3'd0, 1, 0, 0);
    step(0, 3'd0, 0, 1, 0);
    check("os0_done", 32'(done), 1);
    check("os0_borrow", 32'(borrow), 0);

    // load and abort together in DONE: load wins
    step(1, 3'd1, 1, 0, 1);
    check("ld_ab_busy", 32'(busy), 1);
    check("ld_ab_q", 32'(q), 1);
    step(0, 3'd0, 0, 1, 0);
    check("os1_borrow", 32'(borrow), 1);
    step(0, 3'd0, 0, 1, 0);
    check("os1_done", 32'(done), 1);

    // random traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) == 0, W'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
